// File: rtl/field_unpacker_if.sv
// Byte-stream input and field output handshakes of the field unpacker.
// The slave modport is the unpacker itself; master is whoever feeds and drains it.
interface field_unpacker_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_1;
    logic [4:0] out_2;
    logic [4:0] out_3;
    logic [4:0] out_4;
    logic [4:0] out_5;
    logic [4:0] out_6;
    logic       frame_err;
    logic [7:0] err_count;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_1, out_2, out_3, out_4, out_5, out_6,
        input  frame_err, err_count
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_1, out_2, out_3, out_4, out_5, out_6,
        output frame_err, err_count
    );
endinterface

// File: rtl/field_unpacker.sv
// Rebuilds a 32-bit frame from four bytes (MSB first), splits it into six 5-bit
// fields, checks the 2-bit trailer and holds the result in a one-deep output slot.
module field_unpacker #(
    parameter logic [1:0] TRAILER  = 2'b11,
    parameter bit         DROP_BAD = 1'b0
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            flush,
    field_unpacker_if.slave bus
);
    localparam int NUM_FIELDS = 6;
    localparam int FIELD_W    = 5;

    logic [1:0]                           count_reg;
    logic [23:0]                          shift_reg;
    logic                                 out_valid_reg;
    logic                                 frame_err_reg;
    logic [7:0]                           err_count_reg;
    logic [NUM_FIELDS-1:0][FIELD_W-1:0]   field_reg;
    logic [NUM_FIELDS-1:0][FIELD_W-1:0]   field_next;

    logic [31:0] word_next;
    logic        in_ready;
    logic        accept;
    logic        last_byte;
    logic        trailer_bad;
    logic        load_frame;
    logic        pop;

    // Only the final byte of a frame can stall; it waits while the slot is held
    // but goes through in the same cycle the consumer pops.
    assign in_ready    = !flush && !(count_reg == 2'd3 && out_valid_reg && !bus.out_ready);
    assign accept      = bus.in_valid && in_ready;
    assign last_byte   = accept && (count_reg == 2'd3);
    assign word_next   = {shift_reg, bus.in_byte};
    assign trailer_bad = (word_next[1:0] != TRAILER);
    assign load_frame  = last_byte && (!trailer_bad || !DROP_BAD);
    assign pop         = out_valid_reg && bus.out_ready;

    // f1 sits in the top five bits of the word, f6 just above the trailer.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            assign field_next[gi] = word_next[31 - FIELD_W*gi -: FIELD_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            count_reg     <= 2'd0;
            shift_reg     <= 24'd0;
        end else if (flush) begin
            count_reg     <= 2'd0;
        end else if (accept) begin
            count_reg     <= count_reg + 2'd1;
            shift_reg     <= {shift_reg[15:0], bus.in_byte};
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            out_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            field_reg     <= '0;
        end else if (load_frame) begin
            out_valid_reg <= 1'b1;
            frame_err_reg <= trailer_bad;
            field_reg     <= field_next;
        end else if (pop) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Counts every bad trailer, including frames that DROP_BAD discards.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            err_count_reg <= 8'd0;
        end else if (last_byte && trailer_bad && err_count_reg != 8'hFF) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.err_count = err_count_reg;
    assign bus.out_1     = field_reg[0];
    assign bus.out_2     = field_reg[1];
    assign bus.out_3     = field_reg[2];
    assign bus.out_4     = field_reg[3];
    assign bus.out_5     = field_reg[4];
    assign bus.out_6     = field_reg[5];
endmodule

// File: tb/tb_field_unpacker.sv
// Scoreboard bench: dut_keep presents bad frames flagged, dut_drop discards them.
// dut_drop sees exactly the bytes dut_keep accepts, so both track the same stream.
module tb_field_unpacker;
    logic clk;
    logic areset;
    logic flush;

    field_unpacker_if b1 ();
    field_unpacker_if b2 ();

    field_unpacker #(.TRAILER(2'b11), .DROP_BAD(1'b0)) dut_keep (
        .clk(clk), .areset(areset), .flush(flush), .bus(b1.slave)
    );
    field_unpacker #(.TRAILER(2'b11), .DROP_BAD(1'b1)) dut_drop (
        .clk(clk), .areset(areset), .flush(flush), .bus(b2.slave)
    );

    assign b2.in_valid  = b1.in_valid && b1.in_ready;
    assign b2.in_byte   = b1.in_byte;
    assign b2.out_ready = 1'b1;

    typedef struct packed {
        logic [29:0] fields;
        logic        frame_err;
        logic [7:0]  err_count;
    } exp_t;

    exp_t        q1[$];
    logic [29:0] q2[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_err = 0;

    localparam logic [29:0] F_RAMP = {5'd0, 5'd1, 5'd3, 5'd7, 5'd15, 5'd31};
    localparam logic [29:0] F_ONES = {5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
    localparam logic [29:0] F_ONE  = {5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
    localparam logic [29:0] F_MIX  = {5'd20, 5'd21, 5'd13, 5'd12, 5'd6, 5'd15};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor for the flagging instance: every pop must match the oldest expectation.
    always @(negedge clk) begin
        if (!areset && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL keep_unexpected_frame: got fields %0h, required none",
                         {b1.out_1, b1.out_2, b1.out_3, b1.out_4, b1.out_5, b1.out_6});
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("keep_fields", {2'b0, b1.out_1, b1.out_2, b1.out_3, b1.out_4, b1.out_5, b1.out_6},
                      {2'b0, e.fields});
                check("keep_frame_err", {31'd0, b1.frame_err}, {31'd0, e.frame_err});
                check("keep_err_count", {24'd0, b1.err_count}, {24'd0, e.err_count});
            end
            $display("pop keep: fields=%h err=%0d cnt=%0d", {b1.out_1, b1.out_2, b1.out_3,
                     b1.out_4, b1.out_5, b1.out_6}, b1.frame_err, b1.err_count);
        end
    end

    // Monitor for the dropping instance: only good frames may ever appear.
    always @(negedge clk) begin
        if (!areset && b2.out_valid) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drop_unexpected_frame: got fields %0h, required none",
                         {b2.out_1, b2.out_2, b2.out_3, b2.out_4, b2.out_5, b2.out_6});
            end else begin
                logic [29:0] f;
                f = q2.pop_front();
                check("drop_fields", {2'b0, b2.out_1, b2.out_2, b2.out_3, b2.out_4, b2.out_5, b2.out_6},
                      {2'b0, f});
                check("drop_frame_err", {31'd0, b2.frame_err}, 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int stalls);
        stalls = 0;
        b1.in_valid = 1'b1;
        b1.in_byte  = b;
        @(negedge clk);
        while (!b1.in_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (!b1.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", stalls);
        end
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [29:0] fields, input logic bad);
        exp_t e;
        if (bad && exp_err < 255) exp_err++;
        e.fields    = fields;
        e.frame_err = bad;
        e.err_count = exp_err[7:0];
        q1.push_back(e);
        if (!bad) q2.push_back(fields);
    endtask

    task automatic send_frame(input logic [31:0] w, input logic [29:0] fields, input logic bad);
        int st;
        push_exp(fields, bad);
        send_byte(w[31:24], st);
        send_byte(w[23:16], st);
        send_byte(w[15:8], st);
        send_byte(w[7:0], st);
        $display("frame %h issued", w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, {31'd0, b1.out_valid}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, b1.frame_err}, 32'd0);
        check({tag, "_err_count"}, {24'd0, b1.err_count}, 32'd0);
        check({tag, "_fields"}, {2'b0, b1.out_1, b1.out_2, b1.out_3, b1.out_4, b1.out_5, b1.out_6}, 32'd0);
        check({tag, "_drop_err_count"}, {24'd0, b2.err_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        areset       = 1'b1;
        flush        = 1'b0;
        b1.in_valid  = 1'b0;
        b1.in_byte   = 8'h00;
        b1.out_ready = 1'b1;
        idle(3);
        check_all_zero("reset");
        check("reset_in_ready", {31'd0, b1.in_ready}, 32'd1);
        areset = 1'b0;
        idle(2);

        // T1: good frame, output appears on the edge that takes byte 3
        send_frame(32'h004677FF, F_RAMP, 1'b0);
        @(negedge clk);
        check("t1_latency_keep", {31'd0, b1.out_valid}, 32'd1);
        check("t1_latency_drop", {31'd0, b2.out_valid}, 32'd1);
        idle(2);

        // T2: bad trailer; dropping instance stays quiet but still counts
        send_frame(32'h004677FE, F_RAMP, 1'b1);
        @(negedge clk);
        check("t2_keep_valid", {31'd0, b1.out_valid}, 32'd1);
        check("t2_drop_valid", {31'd0, b2.out_valid}, 32'd0);
        check("t2_drop_err_count", {24'd0, b2.err_count}, 32'd1);
        idle(2);

        send_frame(32'hA55AC33C, F_MIX, 1'b1);
        send_frame(32'hFFFFFFFF, F_ONES, 1'b0);
        send_frame(32'h08421087, F_ONE, 1'b0);
        idle(3);

        // T3: slot held, second frame stalls only on its last byte
        b1.out_ready = 1'b0;
        send_frame(32'hFFFFFFFF, F_ONES, 1'b0);
        push_exp(F_ONE, 1'b0);
        send_byte(8'h08, st);
        check("t3_b0_stalls", st, 32'd0);
        send_byte(8'h42, st);
        check("t3_b1_stalls", st, 32'd0);
        send_byte(8'h10, st);
        check("t3_b2_stalls", st, 32'd0);
        b1.in_valid = 1'b1;
        b1.in_byte  = 8'h87;
        repeat (3) begin
            @(negedge clk);
            check("t3_b3_stall", {31'd0, b1.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        b1.out_ready = 1'b1;
        @(negedge clk);
        check("t3_pop_and_accept", {31'd0, b1.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0;
        idle(3);

        // T4: flush mid-frame; byte offered alongside flush must not be taken
        send_byte(8'h00, st);
        send_byte(8'h46, st);
        flush       = 1'b1;
        b1.in_valid = 1'b1;
        b1.in_byte  = 8'hAA;
        @(negedge clk);
        check("t4_flush_in_ready", {31'd0, b1.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush       = 1'b0;
        b1.in_valid = 1'b0;
        send_frame(32'h004677FF, F_RAMP, 1'b0);
        idle(3);

        // T5: asynchronous reset between byte 1 and byte 2
        send_byte(8'h12, st);
        send_byte(8'h34, st);
        #3;
        areset = 1'b1;
        #1;
        check_all_zero("t5_async");
        exp_err = 0;
        #2;
        areset = 1'b0;
        @(posedge clk);
        #1;
        send_frame(32'h004677FF, F_RAMP, 1'b0);
        idle(3);

        // T6: 257 bad frames, counter must stop at 255
        for (int i = 0; i < 257; i++) begin
            send_frame(32'h004677FE, F_RAMP, 1'b1);
        end
        idle(4);
        check("t6_keep_saturate", {24'd0, b1.err_count}, 32'd255);
        check("t6_drop_saturate", {24'd0, b2.err_count}, 32'd255);
        check("end_q1_empty", q1.size(), 32'd0);
        check("end_q2_empty", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
